btn_debounce_ctrl: RTL and testbench

BTN_DEBOUNCE_CTRL -- requirements
Module: btn_debounce_ctrl

---
 rtl/calc_pkg.sv | 36 +++
 rtl/btn_debounce_ctrl_tick_gen.sv | 50 +++++
 rtl/btn_debounce_ctrl.sv | 174 +++++++++++++++++
 tb/tb_btn_debounce_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calc_pkg
// Purpose : Shared definitions for the button debounce controller:
//           per-button FSM state encoding, default timing constants and a
//           helper that derives the tick divider from the clock rates.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Default timing: 100 MHz clock, 1 kHz sample tick, 10 stable ticks.
  localparam int unsigned c_clk_hz_default       = 100_000_000;
  localparam int unsigned c_tick_hz_default      = 1_000;
  localparam int unsigned c_stable_ticks_default = 10;

  // Per-button debounce FSM, 2-bit encoding.
  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    CHK_HI = 2'd1,
    S_HI   = 2'd2,
    CHK_LO = 2'd3
  } btn_state_e;

  // Clock cycles per sample tick. Degenerate rate combinations collapse to
  // a divider of 1 so the counter never gets a zero or negative range.
  function automatic int unsigned tick_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    if ((tick_hz == 0) || (clk_hz < tick_hz)) begin
      return 1;
    end
    return clk_hz / tick_hz;
  endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/btn_debounce_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : tick_gen
// Purpose : Free-running divider producing a one-cycle sample strobe.
//           The counter runs 0 .. (CLK_HZ/TICK_HZ)-1 and wraps; tick is high
//           exactly in the terminal-count cycle.
// Ports   : clkin - sole clock (rising edge)
//           reset - synchronous active-high reset, clears the counter
//           tick  - one-cycle strobe every CLK_HZ/TICK_HZ cycles
// Revision: 1.0 - initial release
// ============================================================================
module tick_gen
  import calc_pkg::*;
#(
  parameter int unsigned CLK_HZ  = c_clk_hz_default,
  parameter int unsigned TICK_HZ = c_tick_hz_default
) (
  input  logic clkin,
  input  logic reset,
  output logic tick
);

  localparam int unsigned c_div = tick_div(CLK_HZ, TICK_HZ);
  localparam int unsigned c_cw  = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_cw-1:0] c_terminal = c_cw'(c_div - 1);

  logic [c_cw-1:0] cnt_q;
  logic [c_cw-1:0] cnt_d;
  logic            w_terminal;

  assign w_terminal = (cnt_q == c_terminal);

  always_comb begin
    cnt_d = w_terminal ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded straight from the counter: after reset the count is 0, which is
  // not terminal for any divider above 1, so tick is low during reset.
  assign tick = w_terminal;

endmodule : tick_gen
`default_nettype wire

// File: rtl/btn_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce_ctrl
// Purpose : Debounces NBTN asynchronous push buttons. Each raw input is
//           double-flop synchronised, then watched by an independent
//           4-state FSM that accepts a level change only after STABLE_TICKS
//           consecutive sample ticks at the new level. A press produces a
//           one-cycle strobe coincident with the rising debounced level.
// Ports   : clkin     - sole clock (rising edge)
//           reset     - synchronous active-high reset
//           btn_raw   - raw button levels, 1 = pressed (asynchronous)
//           btn_level - debounced level per button
//           btn_pulse - one-cycle press strobe per button
//           tick      - shared one-cycle sample strobe
// Revision: 1.0 - initial release
// ============================================================================
module btn_debounce_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned CLK_HZ       = c_clk_hz_default,
  parameter int unsigned TICK_HZ      = c_tick_hz_default,
  parameter int unsigned STABLE_TICKS = c_stable_ticks_default,
  parameter int          NBTN         = 5
) (
  input  logic            clkin,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_pulse,
  output logic            tick
);

  // Counter is wide enough to hold STABLE_TICKS itself.
  localparam int unsigned c_cntw = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [c_cntw-1:0] c_cnt_max  = c_cntw'(STABLE_TICKS);
  localparam logic [c_cntw:0]   c_stable_x = (c_cntw + 1)'(STABLE_TICKS);

  // --------------------------------------------------------------------------
  // Sample-tick generator
  // --------------------------------------------------------------------------
  logic w_tick;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clkin (clkin),
    .reset (reset),
    .tick  (w_tick)
  );

  assign tick = w_tick;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser for every raw input
  // --------------------------------------------------------------------------
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Per-button debounce FSM
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn

    btn_state_e      state_q;
    btn_state_e      state_d;
    logic [c_cntw-1:0] cnt_q;
    logic [c_cntw-1:0] cnt_d;
    logic            pulse_q;
    logic            pulse_d;
    logic            w_sync;
    logic [c_cntw:0] w_cnt_inc;
    logic            w_last;
    logic            w_level;
    logic            w_pulse;

    assign w_sync    = sync2_q[gi];
    assign w_cnt_inc = {1'b0, cnt_q} + 1'b1;
    // This tick is the one that brings the count up to STABLE_TICKS.
    assign w_last    = (w_cnt_inc >= c_stable_x);

    // State register. The press strobe is registered alongside the state so
    // it appears in the first S_HI cycle, aligned with the rising level.
    always_ff @(posedge clkin) begin
      if (reset) begin
        state_q <= S_LO;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    // Next-state logic. Leaving a stable state reacts on any cycle and
    // clears the counter, so a tick in that same cycle is never counted
    // toward the new candidate level.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        S_LO: begin
          if (w_sync) begin
            state_d = CHK_HI;
            cnt_d   = '0;
          end
        end
        CHK_HI: begin
          if (!w_sync) begin
            // Glitch: back to the old level, no output change.
            state_d = S_LO;
            cnt_d   = '0;
          end else if (w_tick) begin
            if (w_last) begin
              state_d = S_HI;
              cnt_d   = '0;
              pulse_d = 1'b1;
            end else if (cnt_q != c_cnt_max) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_HI: begin
          if (!w_sync) begin
            state_d = CHK_LO;
            cnt_d   = '0;
          end
        end
        CHK_LO: begin
          if (w_sync) begin
            state_d = S_HI;
            cnt_d   = '0;
          end else if (w_tick) begin
            if (w_last) begin
              state_d = S_LO;
              cnt_d   = '0;
            end else if (cnt_q != c_cnt_max) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_LO;
          cnt_d   = '0;
        end
      endcase
    end

    // Output decode: the debounced level holds through CHK_LO until the
    // release is confirmed.
    always_comb begin
      w_level = (state_q == S_HI) || (state_q == CHK_LO);
      w_pulse = pulse_q;
    end

    assign btn_level[gi] = w_level;
    assign btn_pulse[gi] = w_pulse;

  end : g_btn

endmodule : btn_debounce_ctrl
`default_nettype wire

// File: tb/tb_btn_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_btn_debounce_ctrl
// Purpose : Directed scoreboard bench for btn_debounce_ctrl with a 10-cycle
//           tick and STABLE_TICKS = 3. "Cycle n" is the n-th clock period
//           after the last edge that sampled reset high.
// Revision: 1.0 - initial release
// ============================================================================
module tb_btn_debounce_ctrl;

  localparam int NBTN = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NBTN-1:0] raw = '0;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] pulse;
  logic            tick;

  always #5 clk = ~clk;

  btn_debounce_ctrl #(
    .CLK_HZ       (1000),
    .TICK_HZ      (100),
    .STABLE_TICKS (3),
    .NBTN         (NBTN)
  ) u_dut (
    .clkin     (clk),
    .reset     (rst),
    .btn_raw   (raw),
    .btn_level (level),
    .btn_pulse (pulse),
    .tick      (tick)
  );

  // Cycle index since the last reset edge.
  int gcyc = 0;
  always @(posedge clk) begin
    if (rst) gcyc <= 0;
    else     gcyc <= gcyc + 1;
  end

  int checks   = 0;
  int failures = 0;

  int              exp_cyc_q[$];
  logic [NBTN-1:0] exp_mask_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, gcyc);
    end
  endtask

  task automatic push(input int cyc, input logic [NBTN-1:0] mask);
    exp_cyc_q.push_back(cyc);
    exp_mask_q.push_back(mask);
  endtask

  // Advance to 1 time unit after the edge that starts cycle n.
  task automatic at(input int n);
    int guard;
    guard = 0;
    while (gcyc != n) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL at_timeout: cycle %0d never reached, now %0d", n, gcyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
      end
    end
  endtask

  // Monitor: tick phase every cycle, press strobes against the scoreboard.
  always @(negedge clk) begin
    check("tick", {31'd0, tick}, {31'd0, (gcyc % 10) == 9});
    if (pulse !== '0) begin
      if (exp_cyc_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got 0x%0h expected none at cycle %0d", pulse, gcyc);
      end else begin
        int              ec;
        logic [NBTN-1:0] em;
        ec = exp_cyc_q.pop_front();
        em = exp_mask_q.pop_front();
        check("pulse_cycle", gcyc, ec);
        check("pulse_mask", {27'd0, pulse}, {27'd0, em});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Button 0 held from before reset release: sync high at cycle 2,
    // CHK_HI from 3, ticks 9/19/29 -> level and pulse at cycle 30.
    raw = 5'b00001;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("level_after_reset", {27'd0, level}, 32'd0);
    push(30, 5'b00001);
    at(29); check("lvl0_before", {27'd0, level}, 32'h00);
    at(30); check("lvl0_rise",   {27'd0, level}, 32'h01);

    // Button 1 high for 15 cycles: only one tick while in CHK_HI -> nothing.
    at(40); raw[1] = 1'b1;
    at(55); raw[1] = 1'b0;
    at(60); check("short_press", {27'd0, level}, 32'h01);

    // Buttons 2 and 3 together: CHK_HI from 73, ticks 79/89/99 -> pulse 100.
    at(70); raw[3:2] = 2'b11;
    push(100, 5'b01100);
    at(99);  check("pair_before", {27'd0, level}, 32'h01);
    at(100); check("pair_rise",   {27'd0, level}, 32'h0D);
    // Release: CHK_LO from 113, ticks 119/129/139 -> level falls at 140.
    at(110); raw[3:2] = 2'b00;
    at(139); check("pair_hold", {27'd0, level}, 32'h0D);
    at(140); check("pair_fall", {27'd0, level}, 32'h01);

    // Button 1 bouncing every 3 cycles over 150..189, then high from 190.
    // Final CHK_HI entered at 193, ticks 199/209/219 -> pulse at 220.
    for (int k = 0; k < 14; k++) begin
      at(150 + 3 * k);
      raw[1] = ((k % 2) == 0);
    end
    at(190); raw[1] = 1'b1;
    push(220, 5'b00010);
    at(219); check("bounce_before", {27'd0, level}, 32'h01);
    at(220); check("bounce_rise",   {27'd0, level}, 32'h03);

    // Button 4 pressed, reset after two counted ticks (239, 249).
    at(230); raw[4] = 1'b1;
    at(250); check("pre_reset", {27'd0, level}, 32'h03);
    rst = 1'b1;
    @(posedge clk);
    #1 check("level_in_reset", {27'd0, level}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // All held buttons (0, 1, 4) need a full debounce again -> pulse at 30.
    push(30, 5'b10011);
    at(29); check("post_reset_before", {27'd0, level}, 32'h00);
    at(30); check("post_reset_rise",   {27'd0, level}, 32'h13);
    at(50);
    check("scoreboard_empty", exp_cyc_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_btn_debounce_ctrl
`default_nettype wire
